logicnets_lut_layer: RTL
========================

LOGICNETS_LUT_LAYER -- requirements
Module: logicnets_lut_layer

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 8: neurons in the layer.
REQ-002 SHALL have parameter FAN_IN, default 8: input bits per neuron (table depth 2**FAN_IN).
REQ-003 SHALL have parameter OUT_BITS, default 1: output bits per neuron.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port in_data, input, NUM_NEURONS*FAN_IN: neuron n address in bits [n*FAN_IN +: FAN_IN].
REQ-007 SHALL have port in_valid, input, 1, and port in_ready, output, 1: input handshake.
REQ-008 SHALL have port out_data, output, NUM_NEURONS*OUT_BITS: neuron n result in bits [n*OUT_BITS +: OUT_BITS].
REQ-009 SHALL have port out_valid, output, 1, and port out_ready, input, 1: output handshake.
REQ-010 SHALL have port cfg_we, input, 1: table write strobe.
REQ-011 SHALL have port cfg_neuron, input, clog2(NUM_NEURONS): target neuron.
REQ-012 SHALL have port cfg_addr, input, FAN_IN: target table entry.
REQ-013 SHALL have port cfg_data, input, OUT_BITS: entry value.
REQ-014 SHALL have port cfg_ready, output, 1: high when a write is accepted.
REQ-015 SHALL have port infer_count, output, 32: count of completed output transfers.

Function
REQ-016 SHALL hold per neuron a writable truth table of 2**FAN_IN entries of OUT_BITS each.
REQ-017 SHALL, on an input transfer (in_valid & in_ready), register the table lookup for every neuron into out_data and set out_valid the next cycle; latency is exactly 1 cycle.
REQ-018 SHALL drive in_ready = (!out_valid | out_ready) & !cfg_we, giving full throughput with one output stage and no bubbles.
REQ-019 SHALL hold out_data and out_valid stable while out_valid & !out_ready.
REQ-020 SHALL clear out_valid after an output transfer unless a new input transfer occurs in the same cycle.
REQ-021 SHALL drive cfg_ready = !out_valid, so table writes occur only while the pipeline is empty.
REQ-022 SHALL, on cfg_we & cfg_ready, write cfg_data to entry cfg_addr of neuron cfg_neuron; the written value is visible to lookups from the next cycle.
REQ-023 SHALL, when cfg_we and in_valid are both high, accept the write (if cfg_ready) and refuse the input (in_ready low).
REQ-024 SHALL ignore cfg_we when cfg_ready is low; no table changes.
REQ-025 SHALL ignore writes with cfg_neuron >= NUM_NEURONS.
REQ-026 SHALL increment infer_count on each output transfer, wrapping modulo 2**32.

Reset
REQ-027 SHALL, with rst high at a clock edge, clear out_valid, out_data and infer_count and zero all table entries.
REQ-028 SHALL let rst override any in-flight transfer or write in the same cycle and discard it.
REQ-029 SHALL drive in_ready = 1 and cfg_ready = 1 in the first cycle after reset.

Structure
REQ-030 SHALL take default parameters and the clog2 helper from shared package logicnets_pkg.
REQ-031 SHALL instantiate one sub-module lut_neuron_table per neuron (write port plus combinational read); the layer owns the handshake, output register and counter.

Verification
REQ-032 Bench SHALL cover reset: after rst, every lookup returns 0, out_valid=0, infer_count=0.
REQ-033 Bench SHALL cover a single write: write neuron 0, addr 8'h80, data 1; present in_data with neuron 0 addr 8'h80 -> out_data[0]=1 one cycle later, all other neurons 0.
REQ-034 Bench SHALL cover streaming: load random tables, hold out_ready=1 for 100 back-to-back inputs -> 100 outputs, one per cycle, each matching the software model, infer_count=100.
REQ-035 Bench SHALL cover backpressure: hold out_ready=0 for 5 cycles with out_valid=1 -> out_data stable and in_ready=0; release -> queued input emitted next cycle.
REQ-036 Bench SHALL cover contention: cfg_we and in_valid high together on an empty pipeline -> write takes effect, in_ready=0; cfg_we with out_valid=1 -> table unchanged.
REQ-037 Bench SHALL cover reset mid-stream: assert rst while out_valid=1 -> out_valid=0, infer_count=0, and tables zeroed the next cycle.

Source files
------------

// File: rtl/logicnets_pkg.sv
// Shared definitions for the LogicNets LUT layer.
// Holds the default layer geometry and a clog2 helper that sizes the
// neuron-select field of the configuration port.
package logicnets_pkg;

  localparam int DEFAULT_NUM_NEURONS = 8;
  localparam int DEFAULT_FAN_IN      = 8;
  localparam int DEFAULT_OUT_BITS    = 1;

  // Ceiling log2, never below 1 so a single-neuron layer still has a
  // one-bit neuron select instead of a zero-width port.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lut_neuron_table.sv
// One neuron's truth table: 2**FAN_IN entries of OUT_BITS each.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (zeroes all entries)
//   we          - write strobe (already qualified by the layer)
//   waddr/wdata - entry to write and its value
//   raddr/rdata - combinational lookup port
module lut_neuron_table
  import logicnets_pkg::*;
#(
  parameter int FAN_IN   = DEFAULT_FAN_IN,
  parameter int OUT_BITS = DEFAULT_OUT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [FAN_IN-1:0]   waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic [FAN_IN-1:0]   raddr,
  output logic [OUT_BITS-1:0] rdata
);

  localparam int DEPTH = 1 << FAN_IN;

  logic [OUT_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/logicnets_lut_layer.sv
// A layer of LUT neurons with a single registered output stage.
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   in_data/in_valid/in_ready    - input stream; neuron n address in
//                                  in_data[n*FAN_IN +: FAN_IN]
//   out_data/out_valid/out_ready - output stream; neuron n result in
//                                  out_data[n*OUT_BITS +: OUT_BITS]
//   cfg_we/cfg_neuron/cfg_addr/cfg_data/cfg_ready - truth table write port
//   infer_count             - completed output transfers, wraps at 2**32
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and data stable until that edge;
// ready may depend combinationally on the consumer side and on cfg_we.
// Table writes are accepted only while the output stage is empty, so a
// lookup already held in out_data never mixes old and new table contents.
module logicnets_lut_layer
  import logicnets_pkg::*;
#(
  parameter int NUM_NEURONS = DEFAULT_NUM_NEURONS,
  parameter int FAN_IN      = DEFAULT_FAN_IN,
  parameter int OUT_BITS    = DEFAULT_OUT_BITS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_NEURONS*FAN_IN-1:0]   in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  input  logic                            cfg_we,
  input  logic [clog2(NUM_NEURONS)-1:0]   cfg_neuron,
  input  logic [FAN_IN-1:0]               cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_data,
  output logic                            cfg_ready,
  output logic [31:0]                     infer_count
);

  localparam int NW = clog2(NUM_NEURONS);

  logic                            in_fire;
  logic                            out_fire;
  logic                            cfg_fire;
  logic [NUM_NEURONS*OUT_BITS-1:0] lookup;

  // A pending write takes the cycle; the input waits.
  assign in_ready  = (!out_valid || out_ready) && !cfg_we;
  assign cfg_ready = !out_valid;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign cfg_fire  = cfg_we && cfg_ready;

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
    logic we_n;
    // Out-of-range neuron selects match no table and are dropped.
    assign we_n = cfg_fire && (cfg_neuron == NW'(n));

    lut_neuron_table #(
      .FAN_IN  (FAN_IN),
      .OUT_BITS(OUT_BITS)
    ) u_table (
      .clk  (clk),
      .rst  (rst),
      .we   (we_n),
      .waddr(cfg_addr),
      .wdata(cfg_data),
      .raddr(in_data[n*FAN_IN +: FAN_IN]),
      .rdata(lookup[n*OUT_BITS +: OUT_BITS])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      infer_count <= '0;
    end else begin
      if (in_fire) begin
        out_valid <= 1'b1;
        out_data  <= lookup;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
      if (out_fire) infer_count <= infer_count + 32'd1;
    end
  end

endmodule
